// File: rtl/phase_stream_rx.sv
// phase_stream_rx: receiving end of the phase generator driver-board link.
// Synchronises the serial lanes and strobes, deserialises each lane into a
// DEPTH-bit shift register, transfers to parallel drive outputs on latch,
// flags frames of the wrong length and measures the sync period.
module phase_stream_rx #(
    parameter int LANES    = 16,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [LANES-1:0]         i_channel,
    input  logic                     i_data_clk,
    input  logic                     i_latch,
    input  logic                     i_sync,
    input  logic                     i_err_clear,
    output logic [LANES*DEPTH-1:0]   o_outputs,
    output logic                     o_update,
    output logic                     o_frame_err,
    output logic [CNT_W-1:0]         o_bit_count,
    output logic                     o_sync_pulse,
    output logic [PERIOD_W-1:0]      o_period,
    output logic                     o_period_valid
);

    localparam logic [CNT_W-1:0]    DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

    // Control strobes are bundled as {sync, latch, data_clk}
    logic [2:0]             ctl_s1, ctl_s2, ctl_s3;
    logic [LANES-1:0]       ch_s1, ch_s2, ch_q;
    logic                   shift_ev, latch_ev, sync_ev;

    logic [LANES*DEPTH-1:0] sr, sr_next;
    logic [CNT_W-1:0]       bit_cnt, cnt_next;

    logic [PERIOD_W-1:0]    period_cnt;
    logic                   armed;

    // Two-flop synchronisers, a delay stage for edge detection, and registered
    // edge flags; lane data is captured alongside the data_clk edge flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ctl_s1   <= '0;
            ctl_s2   <= '0;
            ctl_s3   <= '0;
            ch_s1    <= '0;
            ch_s2    <= '0;
            ch_q     <= '0;
            shift_ev <= 1'b0;
            latch_ev <= 1'b0;
            sync_ev  <= 1'b0;
        end else begin
            ctl_s1   <= {i_sync, i_latch, i_data_clk};
            ctl_s2   <= ctl_s1;
            ctl_s3   <= ctl_s2;
            ch_s1    <= i_channel;
            ch_s2    <= ch_s1;
            ch_q     <= ch_s2;
            {sync_ev, latch_ev, shift_ev} <= ctl_s2 & ~ctl_s3;
        end
    end

    // Next shift-register contents and bit count; a shift coinciding with a
    // latch is folded in first so the latch sees the new bit and count.
    always_comb begin
        sr_next  = sr;
        cnt_next = bit_cnt;
        if (shift_ev) begin
            for (int l = 0; l < LANES; l++) begin
                sr_next[l*DEPTH +: DEPTH] = {sr[l*DEPTH +: DEPTH-1], ch_q[l]};
            end
            if (bit_cnt != CNT_MAX) begin
                cnt_next = bit_cnt + 1'b1;
            end
        end
    end

    // Shift registers, latch transfer and the sticky frame-length error.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sr          <= '0;
            bit_cnt     <= '0;
            o_outputs   <= '0;
            o_update    <= 1'b0;
            o_bit_count <= '0;
            o_frame_err <= 1'b0;
        end else begin
            sr       <= sr_next;
            o_update <= latch_ev;
            if (latch_ev) begin
                o_outputs   <= sr_next;
                o_bit_count <= cnt_next;
                bit_cnt     <= '0;
            end else begin
                bit_cnt     <= cnt_next;
            end
            if (latch_ev && (cnt_next != DEPTH_CNT)) begin
                o_frame_err <= 1'b1;
            end else if (i_err_clear) begin
                o_frame_err <= 1'b0;
            end
        end
    end

    // Sync period measurement; the first edge after reset only arms the counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            period_cnt     <= '0;
            armed          <= 1'b0;
            o_sync_pulse   <= 1'b0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
        end else begin
            o_sync_pulse <= sync_ev;
            if (sync_ev) begin
                period_cnt <= PERIOD_ONE;
                armed      <= 1'b1;
                if (armed) begin
                    o_period       <= period_cnt;
                    o_period_valid <= 1'b1;
                end
            end else if (period_cnt != PERIOD_MAX) begin
                period_cnt <= period_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phase_stream_rx.sv
// Scoreboard testbench for phase_stream_rx: stimulus pushes expected latch
// and sync results into queues, a negedge monitor pops and compares them.
module tb_phase_stream_rx;

    localparam int LANES = 16;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [LANES*DEPTH-1:0] outs;
        logic [7:0]             cnt;
        logic                   err;
    } frame_t;

    typedef struct packed {
        logic [15:0] per;
        logic        vld;
    } sync_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [LANES-1:0]       channel;
    logic                   data_clk, latch, sync, err_clear;
    logic [LANES*DEPTH-1:0] outputs;
    logic                   update, frame_err, sync_pulse, period_valid;
    logic [7:0]             bit_count;
    logic [15:0]            period;

    phase_stream_rx dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_channel      (channel),
        .i_data_clk     (data_clk),
        .i_latch        (latch),
        .i_sync         (sync),
        .i_err_clear    (err_clear),
        .o_outputs      (outputs),
        .o_update       (update),
        .o_frame_err    (frame_err),
        .o_bit_count    (bit_count),
        .o_sync_pulse   (sync_pulse),
        .o_period       (period),
        .o_period_valid (period_valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    frame_t fq[$];
    sync_t  sq[$];

    // Reference model state: the full bit history per lane, frame count,
    // sticky error, and the sync arming/period bookkeeping.
    logic [63:0]     hist [LANES];
    int              cnt_m;
    bit              err_m;
    bit              armed_m;
    int unsigned     last_sync;
    logic [15:0]     period_m;
    bit              valid_m;
    logic [LANES-1:0] pat [10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) hist[l] = '0;
        cnt_m    = 0;
        err_m    = 0;
        armed_m  = 0;
        period_m = '0;
        valid_m  = 0;
    endtask

    task automatic model_bit(input logic [LANES-1:0] w);
        for (int l = 0; l < LANES; l++) hist[l] = hist[l] * 2 + 64'(w[l]);
        if (cnt_m < 255) cnt_m++;
    endtask

    // Frame of n pulses from pat[]; simul raises the last data_clk with latch;
    // clr asserts err_clear on the very cycle the latch is acted on.
    task automatic send_frame(input int n, input int hi, input int lo, input bit simul, input bit clr);
        frame_t f;
        int     found;
        int     full;
        full = simul ? n - 1 : n;
        for (int i = 0; i < full; i++) begin
            channel  = pat[i];
            data_clk = 1'b1;
            model_bit(pat[i]);
            cyc_wait(hi);
            data_clk = 1'b0;
            cyc_wait(lo);
        end
        if (simul) begin
            channel  = pat[n-1];
            data_clk = 1'b1;
            model_bit(pat[n-1]);
        end
        latch = 1'b1;
        for (int l = 0; l < LANES; l++) f.outs[l*DEPTH +: DEPTH] = hist[l][7:0];
        f.cnt = 8'(cnt_m);
        if (cnt_m != DEPTH) err_m = 1;
        else if (clr) err_m = 0;
        f.err = err_m;
        fq.push_back(f);
        cnt_m = 0;
        found = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc_wait(1);
            if (clr) err_clear = (k == 3);
            if (k == 4) begin
                latch    = 1'b0;
                data_clk = 1'b0;
            end
            if (update && found == 0) found = k;
        end
        err_clear = 1'b0;
        check("update_latency", 128'(found), 128'd4);
        cyc_wait(lo);
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1;
        cyc_wait(1);
        err_clear = 1'b0;
        err_m = 0;
        check("err_clear", 128'(frame_err), 128'd0);
    endtask

    task automatic send_sync(input int gap);
        sync_t s;
        sync = 1'b1;
        if (armed_m) begin
            period_m = ((cyc - last_sync) > 65535) ? 16'hFFFF : 16'(cyc - last_sync);
            valid_m  = 1;
        end
        armed_m   = 1;
        last_sync = cyc;
        s.per = period_m;
        s.vld = valid_m;
        sq.push_back(s);
        cyc_wait(4);
        sync = 1'b0;
        cyc_wait(gap - 4);
    endtask

    task automatic check_reset_state();
        check("rst_outputs", 128'(outputs), 128'd0);
        check("rst_update", 128'(update), 128'd0);
        check("rst_frame_err", 128'(frame_err), 128'd0);
        check("rst_bit_count", 128'(bit_count), 128'd0);
        check("rst_sync_pulse", 128'(sync_pulse), 128'd0);
        check("rst_period", 128'(period), 128'd0);
        check("rst_period_valid", 128'(period_valid), 128'd0);
    endtask

    // Monitor: compare each DUT presentation against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && update === 1'b1) begin
            if (fq.size() == 0) begin
                check("unexpected_update", 128'd1, 128'd0);
            end else begin
                frame_t f;
                f = fq.pop_front();
                check("frame_outputs", 128'(outputs), 128'(f.outs));
                check("frame_bit_count", 128'(bit_count), 128'(f.cnt));
                check("frame_err", 128'(frame_err), 128'(f.err));
            end
        end
        if (rst_n === 1'b1 && sync_pulse === 1'b1) begin
            if (sq.size() == 0) begin
                check("unexpected_sync", 128'd1, 128'd0);
            end else begin
                sync_t s;
                s = sq.pop_front();
                check("sync_period", 128'(period), 128'(s.per));
                check("sync_valid", 128'(period_valid), 128'(s.vld));
            end
        end
    end

    initial begin
        logic [7:0] a_bits;
        int         wait_n;
        rst_n = 1'b0; channel = '0; data_clk = 1'b0; latch = 1'b0;
        sync = 1'b0; err_clear = 1'b0;
        model_reset();
        cyc_wait(3);
        check_reset_state();
        rst_n = 1'b1;
        cyc_wait(4);

        // Lane 0 carries 1,0,1,1,0,0,1,0; first bit lands at bit 7
        a_bits = 8'hB2;
        for (int i = 0; i < 8; i++) pat[i] = {15'd0, a_bits[7-i]};
        send_frame(8, 4, 4, 0, 0);
        check("lane0_B2", 128'(outputs[7:0]), 128'hB2);

        // Lane n carries the value n
        for (int i = 0; i < 8; i++)
            for (int l = 0; l < LANES; l++) begin
                logic [7:0] v;
                v = 8'(l);
                pat[i][l] = v[7-i];
            end
        send_frame(8, 3, 3, 0, 0);
        for (int l = 0; l < LANES; l++) check("lane_value", 128'(outputs[l*8 +: 8]), 128'(l));

        // Short frame sets the sticky error, good frame leaves it, clear drops it
        for (int i = 0; i < 10; i++) pat[i] = 16'($urandom);
        send_frame(7, 2, 3, 0, 0);
        send_frame(8, 2, 2, 0, 0);
        pulse_err_clear();
        send_frame(9, 3, 2, 0, 1);
        check("err_set_wins", 128'(frame_err), 128'd1);
        pulse_err_clear();

        // data_clk and latch on the same pin cycle after 7 pulses
        for (int i = 0; i < 10; i++) pat[i] = 16'($urandom);
        send_frame(8, 4, 4, 1, 0);
        check("simul_no_err", 128'(frame_err), 128'd0);

        // Three syncs 600 cycles apart
        send_sync(600);
        send_sync(600);
        send_sync(600);
        check("period_600", 128'(period), 128'd600);

        // Randomised frames and sync gaps
        for (int it = 0; it < 8; it++) begin
            int n;
            for (int i = 0; i < 10; i++) pat[i] = 16'($urandom);
            n = $urandom_range(7, 9);
            if ($urandom_range(0, 2) == 0) pulse_err_clear();
            send_frame(n, $urandom_range(2, 5), $urandom_range(2, 5),
                       ($urandom_range(0, 3) == 0), 0);
            send_sync($urandom_range(20, 1500));
        end

        // Reset mid-frame after 4 bits; data_clk is low when reset hits
        for (int i = 0; i < 4; i++) begin
            channel  = 16'($urandom);
            data_clk = 1'b1;
            cyc_wait(3);
            data_clk = 1'b0;
            cyc_wait(3);
        end
        rst_n = 1'b0;
        cyc_wait(1);
        rst_n = 1'b1;
        model_reset();
        check_reset_state();
        cyc_wait(3);
        for (int i = 0; i < 10; i++) pat[i] = 16'($urandom);
        send_frame(8, 3, 3, 0, 0);
        check("post_rst_count", 128'(bit_count), 128'd8);
        check("post_rst_no_err", 128'(frame_err), 128'd0);
        check("post_rst_pvalid", 128'(period_valid), 128'd0);
        send_sync(300);
        check("pvalid_one_sync", 128'(period_valid), 128'd0);
        send_sync(300);
        check("pvalid_two_syncs", 128'(period_valid), 128'd1);

        // Drain the scoreboard with a bounded wait
        wait_n = 0;
        while ((fq.size() != 0 || sq.size() != 0) && wait_n < 50) begin
            cyc_wait(1);
            wait_n++;
        end
        check("frame_queue_drained", 128'(fq.size()), 128'd0);
        check("sync_queue_drained", 128'(sq.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
